ram_host_arbiter: RTL and testbench

- Shares the single-port `ram` between the `microprocessor` and the host channel pipes of `comm_fpga_fx2`.
- The host can halt and run the CPU, set a 16-bit memory address, and stream bytes into or out of RAM for program load and readback.
- A CPU clock enable freezes the CPU while the host owns the RAM.
- After each host access the block replays the CPU's own address, so the CPU never sees stale `ram_dout`.

---
 rtl/ram_host_arbiter_if.sv | 38 +++
 rtl/ram_host_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_host_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_host_arbiter_if.sv
// Bus bundle between ram_host_arbiter and its neighbours: host channel pipes, CPU port and RAM port.
interface ram_host_arbiter_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 7;

    logic [CW-1:0] chan_addr;
    logic [DW-1:0] h2f_data;
    logic          h2f_valid;
    logic          h2f_ready;
    logic [DW-1:0] f2h_data;
    logic          f2h_valid;
    logic          f2h_ready;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_we;
    logic [DW-1:0] cpu_dout;
    logic          cpu_ce;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          run;

    modport slave (
        input  chan_addr, h2f_data, h2f_valid, f2h_ready,
        input  cpu_addr, cpu_din, cpu_we, ram_dout,
        output h2f_ready, f2h_data, f2h_valid,
        output cpu_dout, cpu_ce, ram_addr, ram_din, ram_we, run
    );

    modport master (
        output chan_addr, h2f_data, h2f_valid, f2h_ready,
        output cpu_addr, cpu_din, cpu_we, ram_dout,
        input  h2f_ready, f2h_data, f2h_valid,
        input  cpu_dout, cpu_ce, ram_addr, ram_din, ram_we, run
    );
endinterface

// File: rtl/ram_host_arbiter.sv
// Shares a single-port RAM between the CPU and the host channel pipes; host can halt/run the CPU.
// Optional MEM_BRIDGE_AUTOINC_EN: mar post-increments on every completed DATA transfer.
module ram_host_arbiter #(
    parameter logic [6:0] CH_BASE      = 7'h10,
    parameter bit         RUN_ON_RESET = 1'b0
) (
    input logic           clk,
    input logic           reset,
    ram_host_arbiter_if.slave bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 7;

    localparam logic [CW-1:0] CH_ADDR_LO = CH_BASE;
    localparam logic [CW-1:0] CH_ADDR_HI = CH_BASE + 7'd1;
    localparam logic [CW-1:0] CH_DATA    = CH_BASE + 7'd2;
    localparam logic [CW-1:0] CH_CTRL    = CH_BASE + 7'd3;

    typedef enum logic [2:0] {
        S_RUN, S_HALT, S_PAUSE, S_H_WR, S_H_RD, S_RD_DATA, S_RESTORE
    } state_t;

    localparam state_t S_INIT = RUN_ON_RESET ? S_RUN : S_HALT;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_mar;
    logic          r_run;
    logic [DW-1:0] r_f2h_data;
    logic          r_rd_fresh;
    logic          r_dir_wr;

    logic          w_sel_data;
    logic          w_wr_pend;
    logic          w_rd_pend;
    logic          w_reg_wr;
    logic [DW-1:0] w_reg_rd_data;
    logic [AW-1:0] w_ram_addr;
    logic [DW-1:0] w_ram_din;
    logic          w_ram_we;
    logic          w_cpu_ce;
    logic          w_h2f_ready;
    logic          w_f2h_valid;
    logic [DW-1:0] w_f2h_data;

    assign w_sel_data = (bus.chan_addr == CH_DATA);
    assign w_wr_pend  = w_sel_data && bus.h2f_valid;
    assign w_rd_pend  = w_sel_data && bus.f2h_ready;
    assign w_reg_wr   = ((r_state == S_RUN) || (r_state == S_HALT)) && bus.h2f_valid && !w_sel_data;

    always_comb begin
        w_reg_rd_data = '0;
        if (bus.chan_addr == CH_ADDR_LO)      w_reg_rd_data = r_mar[7:0];
        else if (bus.chan_addr == CH_ADDR_HI) w_reg_rd_data = r_mar[15:8];
        else if (bus.chan_addr == CH_CTRL)    w_reg_rd_data = {7'b0, r_run};
    end

    // Next state: a CTRL run request in HALT wins over a DATA access so it is served first.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_wr_pend || w_rd_pend) w_state_nxt = S_PAUSE;
                else if (!r_run)            w_state_nxt = S_HALT;
            end
            S_HALT: begin
                if (r_run)          w_state_nxt = S_RUN;
                else if (w_wr_pend) w_state_nxt = S_H_WR;
                else if (w_rd_pend) w_state_nxt = S_H_RD;
            end
            S_PAUSE:   w_state_nxt = r_dir_wr ? S_H_WR : S_H_RD;
            S_H_WR:    w_state_nxt = S_RESTORE;
            S_H_RD:    w_state_nxt = S_RD_DATA;
            S_RD_DATA: if (bus.f2h_ready) w_state_nxt = S_RESTORE;
            S_RESTORE: w_state_nxt = r_run ? S_RUN : S_HALT;
            default:   w_state_nxt = S_HALT;
        endcase
    end

    // RAM mux and host handshakes; reset forces every strobe inactive in the same cycle.
    always_comb begin
        w_ram_addr  = bus.cpu_addr;
        w_ram_din   = bus.cpu_din;
        w_ram_we    = 1'b0;
        w_cpu_ce    = 1'b0;
        w_h2f_ready = 1'b0;
        w_f2h_valid = 1'b0;
        w_f2h_data  = w_reg_rd_data;
        case (r_state)
            S_RUN: begin
                w_ram_we    = bus.cpu_we;
                w_cpu_ce    = 1'b1;
                w_h2f_ready = !w_sel_data;
                w_f2h_valid = !w_sel_data;
            end
            S_HALT: begin
                w_h2f_ready = !w_sel_data;
                w_f2h_valid = !w_sel_data;
            end
            S_H_WR: begin
                w_ram_addr  = r_mar;
                w_ram_din   = bus.h2f_data;
                w_ram_we    = 1'b1;
                w_h2f_ready = 1'b1;
            end
            S_H_RD: w_ram_addr = r_mar;
            S_RD_DATA: begin
                w_ram_addr  = r_mar;
                w_f2h_valid = 1'b1;
                w_f2h_data  = r_rd_fresh ? bus.ram_dout : r_f2h_data;
            end
            default: ;
        endcase
        if (reset) begin
            w_ram_we    = 1'b0;
            w_cpu_ce    = RUN_ON_RESET;
            w_h2f_ready = 1'b0;
            w_f2h_valid = 1'b0;
            w_f2h_data  = '0;
        end
    end

`ifdef MEM_BRIDGE_AUTOINC_EN
    logic w_xfer_done;
    assign w_xfer_done = (r_state == S_H_WR) || ((r_state == S_RD_DATA) && bus.f2h_ready);
`endif

    // r_rd_fresh marks the first RD_DATA cycle, when the synchronous RAM read has just landed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_mar      <= '0;
            r_run      <= RUN_ON_RESET;
            r_f2h_data <= '0;
            r_rd_fresh <= 1'b0;
            r_dir_wr   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_fresh <= (r_state == S_H_RD);
            if (r_rd_fresh)        r_f2h_data <= bus.ram_dout;
            if (r_state == S_RUN)  r_dir_wr   <= w_wr_pend;
            if (w_reg_wr) begin
                if (bus.chan_addr == CH_ADDR_LO) r_mar[7:0]  <= bus.h2f_data;
                if (bus.chan_addr == CH_ADDR_HI) r_mar[15:8] <= bus.h2f_data;
                if (bus.chan_addr == CH_CTRL)    r_run       <= bus.h2f_data[0];
            end
`ifdef MEM_BRIDGE_AUTOINC_EN
            if (w_xfer_done) r_mar <= r_mar + 16'd1;
`endif
        end
    end

    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_din   = w_ram_din;
    assign bus.ram_we    = w_ram_we;
    assign bus.cpu_ce    = w_cpu_ce;
    assign bus.cpu_dout  = bus.ram_dout;
    assign bus.h2f_ready = w_h2f_ready;
    assign bus.f2h_valid = w_f2h_valid;
    assign bus.f2h_data  = w_f2h_data;
    assign bus.run       = r_run;
endmodule

// File: tb/tb_ram_host_arbiter.sv
// Directed bench for ram_host_arbiter with a synchronous RAM model and a tiny CPU that stores a pattern.
module tb_ram_host_arbiter;
    localparam logic [6:0] CH_LO   = 7'h10;
    localparam logic [6:0] CH_HI   = 7'h11;
    localparam logic [6:0] CH_DATA = 7'h12;
    localparam logic [6:0] CH_CTRL = 7'h13;
    localparam logic [6:0] CH_NONE = 7'h05;
`ifdef MEM_BRIDGE_AUTOINC_EN
    localparam int unsigned AUTOINC = 1;
`else
    localparam int unsigned AUTOINC = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_host_arbiter_if bus ();

    ram_host_arbiter #(.CH_BASE(7'h10), .RUN_ON_RESET(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [7:0] mem [0:65535] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    // CPU stand-in: while enabled, writes pc^5A to 0x0200+pc for 40 steps.
    logic [7:0] pc;
    always @(posedge clk) begin
        if (reset) pc <= 8'd0;
        else if (bus.cpu_ce && pc < 8'd40) pc <= pc + 8'd1;
    end
    assign bus.cpu_addr = 16'h0200 + {8'h00, pc};
    assign bus.cpu_din  = pc ^ 8'h5A;
    assign bus.cpu_we   = (pc < 8'd40);

    int n_we = 0, n_we_all = 0, n_hrdy = 0, n_ce_low = 0, n_ce_high = 0;
    always @(posedge clk) begin
        if (bus.ram_we && !bus.cpu_ce) n_we <= n_we + 1;
        if (bus.ram_we) n_we_all <= n_we_all + 1;
        if (bus.h2f_ready && bus.h2f_valid && bus.chan_addr == CH_DATA) n_hrdy <= n_hrdy + 1;
        if (bus.cpu_ce) n_ce_high <= n_ce_high + 1;
        else            n_ce_low  <= n_ce_low + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [6:0] ch, input logic [7:0] d);
        int n;
        bus.chan_addr = ch;
        bus.h2f_data  = d;
        bus.h2f_valid = 1'b1;
        #1;
        n = 0;
        while (bus.h2f_ready !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("host_write_handshake", 32'(n < 20), 32'd1);
        tick();
        bus.h2f_valid = 1'b0;
    endtask

    task automatic reg_read(input logic [6:0] ch, input logic [7:0] exp, input string tag);
        bus.chan_addr = ch;
        bus.f2h_ready = 1'b1;
        #1;
        chk("reg_read_valid", 32'(bus.f2h_valid), 32'd1);
        chk(tag, 32'(bus.f2h_data), 32'(exp));
        tick();
        bus.f2h_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad, we0, hr0, ce0;
        reset         = 1'b1;
        bus.chan_addr = CH_DATA;
        bus.h2f_data  = 8'h00;
        bus.h2f_valid = 1'b0;
        bus.f2h_ready = 1'b0;
        repeat (3) tick();
        chk("rst_f2h_valid", 32'(bus.f2h_valid), 32'd0);
        chk("rst_ram_we",    32'(bus.ram_we),    32'd0);
        chk("rst_h2f_ready", 32'(bus.h2f_ready), 32'd0);
        chk("rst_cpu_ce",    32'(bus.cpu_ce),    32'd0);
        chk("rst_f2h_data",  32'(bus.f2h_data),  32'd0);
        reset = 1'b0;
        tick();
        chk("halt_cpu_ce",   32'(bus.cpu_ce),   32'd0);
        chk("halt_run",      32'(bus.run),      32'd0);
        chk("halt_ram_addr", 32'(bus.ram_addr), 32'h0200);
        chk("halt_data_idle_ready", 32'(bus.h2f_ready), 32'd0);
        reg_read(CH_LO,   8'h00, "mar_lo_reset");
        reg_read(CH_HI,   8'h00, "mar_hi_reset");
        reg_read(CH_CTRL, 8'h00, "ctrl_reset");
        host_write(CH_NONE, 8'hFF);
        reg_read(CH_NONE, 8'h00, "unmapped_read");
        reg_read(CH_LO,   8'h00, "unmapped_write_ignored");

        // Halted program load of one byte
        host_write(CH_HI, 8'h00);
        host_write(CH_LO, 8'h20);
        we0 = n_we; hr0 = n_hrdy; ce0 = n_ce_high;
        host_write(CH_DATA, 8'hA5);
        repeat (3) tick();
        chk("load_mem",          32'(mem[16'h0020]),     32'hA5);
        chk("load_we_pulses",    32'(n_we - we0),        32'd1);
        chk("load_ready_cycles", 32'(n_hrdy - hr0),      32'd1);
        chk("load_cpu_ce_high",  32'(n_ce_high - ce0),   32'd0);
        reg_read(CH_LO, 8'(8'h20 + AUTOINC), "load_mar_lo");

        // Readback with a host that stalls five cycles
        host_write(CH_LO, 8'h20);
        bus.chan_addr = CH_DATA;
        bus.f2h_ready = 1'b1;
        #1;
        chk("rd_pending_no_valid", 32'(bus.f2h_valid), 32'd0);
        tick();
        bus.f2h_ready = 1'b0;
        #1;
        chk("rd_hrd_no_valid", 32'(bus.f2h_valid), 32'd0);
        chk("rd_hrd_addr",     32'(bus.ram_addr),  32'h0020);
        tick();
        #1;
        chk("rd_first", {23'd0, bus.f2h_valid, bus.f2h_data}, 32'h1A5);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk("rd_hold", {23'd0, bus.f2h_valid, bus.f2h_data}, 32'h1A5);
        end
        bus.f2h_ready = 1'b1;
        tick();
        bus.f2h_ready = 1'b0;
        #1;
        chk("rd_restore_valid", 32'(bus.f2h_valid), 32'd0);
        chk("rd_restore_addr",  32'(bus.ram_addr),  32'h0200);
        tick();
        chk("rd_back_halt_ce", 32'(bus.cpu_ce), 32'd0);
        reg_read(CH_LO, 8'(8'h20 + AUTOINC), "rd_mar_lo");

        // Run the CPU, then interrupt it with one host DATA write
        host_write(CH_CTRL, 8'h01);
        chk("run_bit", 32'(bus.run), 32'd1);
        repeat (2) tick();
        chk("run_ce", 32'(bus.cpu_ce), 32'd1);
        host_write(CH_HI, 8'h01);
        host_write(CH_LO, 8'h00);
        ce0 = n_ce_low;
        host_write(CH_DATA, 8'h3C);
        repeat (4) tick();
        chk("irq_ce_low_cycles", 32'(n_ce_low - ce0), 32'd3);
        n = 0;
        while (pc != 8'd40 && n < 200) begin
            tick();
            n++;
        end
        chk("cpu_done", 32'(pc), 32'd40);
        chk("irq_mem", 32'(mem[16'h0100]), 32'h3C);
        bad = 0;
        for (int k = 0; k < 40; k++)
            if (mem[16'h0200 + 16'(k)] !== (8'(k) ^ 8'h5A)) bad++;
        chk("cpu_golden", 32'(bad), 32'd0);
        host_write(CH_CTRL, 8'h00);
        repeat (2) tick();
        chk("halted_again_ce", 32'(bus.cpu_ce), 32'd0);

        // Two back-to-back DATA writes at the top of memory
        host_write(CH_HI, 8'hFF);
        host_write(CH_LO, 8'hFF);
        host_write(CH_DATA, 8'h11);
        host_write(CH_DATA, 8'h22);
        repeat (3) tick();
`ifdef MEM_BRIDGE_AUTOINC_EN
        chk("wrap_mem_ffff", 32'(mem[16'hFFFF]), 32'h11);
        chk("wrap_mem_0000", 32'(mem[16'h0000]), 32'h22);
        reg_read(CH_LO, 8'h01, "wrap_mar_lo");
        reg_read(CH_HI, 8'h00, "wrap_mar_hi");
`else
        chk("noinc_mem_ffff", 32'(mem[16'hFFFF]), 32'h22);
        chk("noinc_mem_0000", 32'(mem[16'h0000]), 32'h00);
        reg_read(CH_LO, 8'hFF, "noinc_mar_lo");
        reg_read(CH_HI, 8'hFF, "noinc_mar_hi");
`endif

        // Reset while the host read is parked in RD_DATA
        host_write(CH_HI, 8'h00);
        host_write(CH_LO, 8'h20);
        host_write(CH_CTRL, 8'h01);
        repeat (2) tick();
        we0 = n_we_all;
        bus.chan_addr = CH_DATA;
        bus.f2h_ready = 1'b1;
        tick();
        bus.f2h_ready = 1'b0;
        #1;
        n = 0;
        while (bus.f2h_valid !== 1'b1 && n < 10) begin
            tick();
            #1;
            n++;
        end
        chk("rst_rd_reached", 32'(n < 10), 32'd1);
        chk("rst_rd_data", 32'(bus.f2h_data), 32'hA5);
        reset = 1'b1;
        tick();
        chk("midrst_f2h_valid", 32'(bus.f2h_valid), 32'd0);
        chk("midrst_ram_we",    32'(bus.ram_we),    32'd0);
        chk("midrst_run",       32'(bus.run),       32'd0);
        reset = 1'b0;
        tick();
        chk("midrst_mem",    32'(mem[16'h0020]),    32'hA5);
        chk("midrst_no_we",  32'(n_we_all - we0),   32'd0);
        chk("midrst_cpu_ce", 32'(bus.cpu_ce),       32'd0);
        reg_read(CH_LO, 8'h00, "midrst_mar_lo");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
